// File: rtl/adc_rdata_ctrl_if.sv
// rtl/adc_rdata_ctrl_if.sv - byte-engine handshake between the RDATA sequencer and the SPI engine
interface adc_rdata_ctrl_if;
    logic       spi_start_o;
    logic [7:0] spi_tx_o;
    logic [7:0] spi_rx_i;
    logic       spi_done_i;

    modport master (
        output spi_start_o,
        output spi_tx_o,
        input  spi_rx_i,
        input  spi_done_i
    );

    modport slave (
        input  spi_start_o,
        input  spi_tx_o,
        output spi_rx_i,
        output spi_done_i
    );
endinterface

// File: rtl/adc_rdata_ctrl.sv
// rtl/adc_rdata_ctrl.sv - DRDY-triggered RDATA frame sequencer producing 24-bit ADC samples
module adc_rdata_ctrl #(
    parameter logic [7:0]  CMD_RDATA = 8'h01,
    parameter int unsigned T6_CYCLES = 650
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    DRDY_n_i,
    adc_rdata_ctrl_if.master        spi,
    output logic                    CS_o,
    output logic [23:0]             sample_o,
    output logic                    sample_valid_o,
    output logic                    busy_o,
    output logic                    overrun_o
);

    localparam int unsigned T6_W = $clog2(T6_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DRDY,
        S_CMD,
        S_T6,
        S_RD_START,
        S_RD_WAIT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            drdy_meta_q, drdy_sync_q, drdy_prev_q;
    logic            drdy_fall;
    logic            start_q, start_d;
    logic [7:0]      tx_q, tx_d;
    logic            cs_q, cs_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic [23:0]     sample_q, sample_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [T6_W-1:0] t6_q, t6_d;
    logic [1:0]      byte_q, byte_d;

    // Sync chain idles high so a DRDY already low at reset release reads as an edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            drdy_meta_q <= 1'b1;
            drdy_sync_q <= 1'b1;
            drdy_prev_q <= 1'b1;
        end else begin
            drdy_meta_q <= DRDY_n_i;
            drdy_sync_q <= drdy_meta_q;
            drdy_prev_q <= drdy_sync_q;
        end
    end

    assign drdy_fall = drdy_prev_q & ~drdy_sync_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            tx_q      <= 8'h00;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            sample_q  <= 24'h000000;
            shreg_q   <= 16'h0000;
            t6_q      <= '0;
            byte_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            tx_q      <= tx_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            sample_q  <= sample_d;
            shreg_q   <= shreg_d;
            t6_q      <= t6_d;
            byte_q    <= byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        tx_d      = tx_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        sample_d  = sample_q;
        shreg_d   = shreg_q;
        t6_d      = t6_q;
        byte_d    = byte_q;

        // A frame in flight cannot take another edge; it is flagged and dropped.
        if (drdy_fall && (state_q != S_IDLE) && (state_q != S_WAIT_DRDY)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                cs_d   = 1'b1;
                busy_d = 1'b0;
                if (enable_i) begin
                    state_d = S_WAIT_DRDY;
                end else begin
                    overrun_d = 1'b0;
                end
            end
            S_WAIT_DRDY: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (drdy_fall) begin
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    tx_d    = CMD_RDATA;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (spi.spi_done_i && !start_q) begin
                    t6_d    = T6_W'(T6_CYCLES);
                    state_d = S_T6;
                end
            end
            S_T6: begin
                t6_d = t6_q - 1'b1;
                // First data start leaves straight from the last T6 cycle to land exactly T6_CYCLES after entry.
                if (t6_q == T6_W'(1)) begin
                    start_d = 1'b1;
                    tx_d    = 8'h00;
                    byte_d  = byte_q + 2'd1;
                    state_d = S_RD_START;
                end
            end
            S_RD_START: begin
                state_d = S_RD_WAIT;
                if (!start_q) begin
                    start_d = 1'b1;
                    tx_d    = 8'h00;
                    byte_d  = byte_q + 2'd1;
                end
            end
            S_RD_WAIT: begin
                if (spi.spi_done_i && !start_q) begin
                    shreg_d = {shreg_q[7:0], spi.spi_rx_i};
                    if (byte_q < 2'd3) begin
                        state_d = S_RD_START;
                    end else begin
                        sample_d = {shreg_q, spi.spi_rx_i};
                        valid_d  = 1'b1;
                        cs_d     = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                byte_d  = 2'd0;
                state_d = enable_i ? S_WAIT_DRDY : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign spi.spi_start_o = start_q;
    assign spi.spi_tx_o    = tx_q;
    assign CS_o            = cs_q;
    assign sample_o        = sample_q;
    assign sample_valid_o  = valid_q;
    assign busy_o          = busy_q;
    assign overrun_o       = overrun_q;

endmodule
